division: RTL and testbench



---
 rtl/division_pkg.sv | 20 ++
 rtl/division_if.sv | 24 ++
 rtl/division_step.sv | 32 +++
 rtl/division.sv | 109 ++++++++++
 tb/tb_division.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/division_pkg.sv
// Shared definitions for the restoring divider: default width, FSM encoding,
// and the width of the iteration counter.
package division_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_RUN  = RUN;

   // Counter must hold the value WIDTH itself, hence WIDTH+1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/division_if.sv
// Operand/result bundle for the divider. DIVISION_DBZ_FLAG_EN adds the
// registered div_by_zero flag.
interface division_if import division_pkg::*; #(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
`ifdef DIVISION_DBZ_FLAG_EN
   logic             div_by_zero;

   modport master (output start, a, b, input q, r, busy, done, div_by_zero);
   modport slave  (input start, a, b, output q, r, busy, done, div_by_zero);
`else
   modport master (output start, a, b, input q, r, busy, done);
   modport slave  (input start, a, b, output q, r, busy, done);
`endif

endinterface

// File: rtl/division_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when it fits.
module division_step import division_pkg::*; #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] diff_s;

   assign shifted_s = {rem, msb};
   assign diff_s    = shifted_s - {1'b0, divisor};

   // A clear borrow bit means the divisor fits into the shifted remainder.
   always_comb begin
      rem_next = shifted_s[WIDTH-1:0];
      q_bit    = 1'b0;
      if (diff_s[WIDTH] == 1'b0) begin
         rem_next = diff_s[WIDTH-1:0];
         q_bit    = 1'b1;
      end else begin
         rem_next = shifted_s[WIDTH-1:0];
         q_bit    = 1'b0;
      end
   end

endmodule

// File: rtl/division.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIVISION_DBZ_FLAG_EN adds a registered divide-by-zero flag.
module division import division_pkg::*; #(
   parameter int WIDTH = DIV_WIDTH
) (
   input logic       clock,
   input logic       reset,
   division_if.slave bus
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [0:0]       state_r;
   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] rem_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] r_r;
   logic             busy_r;
   logic             done_r;

   logic [WIDTH-1:0] rem_next_s;
   logic             q_bit_s;
   logic [WIDTH-1:0] quo_next_s;
   logic             finish_s;

   division_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_r),
      .msb      (dvd_r[WIDTH-1]),
      .divisor  (dvs_r),
      .rem_next (rem_next_s),
      .q_bit    (q_bit_s)
   );

   // Quotient bits fill the dividend register from the LSB as its MSBs shift out.
   assign quo_next_s = {dvd_r[WIDTH-2:0], q_bit_s};
   assign finish_s   = (state_r == ST_RUN) && (cnt_r == CNT_ONE);

   // Control FSM, working registers and result registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         dvd_r   <= {WIDTH{1'b0}};
         dvs_r   <= {WIDTH{1'b0}};
         rem_r   <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
         q_r     <= {WIDTH{1'b0}};
         r_r     <= {WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  dvd_r   <= bus.a;
                  dvs_r   <= bus.b;
                  rem_r   <= {WIDTH{1'b0}};
                  cnt_r   <= CNT_LOAD;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end
            end
            ST_RUN: begin
               dvd_r <= quo_next_s;
               rem_r <= rem_next_s;
               cnt_r <= cnt_r - CNT_ONE;
               if (finish_s) begin
                  q_r     <= quo_next_s;
                  r_r     <= rem_next_s;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.q    = q_r;
   assign bus.r    = r_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

`ifdef DIVISION_DBZ_FLAG_EN
   logic dbz_r;

   // Flag follows the divisor of the most recently completed operation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dbz_r <= 1'b0;
      end else if (finish_s) begin
         dbz_r <= (dvs_r == {WIDTH{1'b0}});
      end else begin
         dbz_r <= dbz_r;
      end
   end

   assign bus.div_by_zero = dbz_r;
`endif

endmodule

// File: tb/tb_division.sv
// Scoreboard bench for the restoring divider: expected q/r are queued at
// start and compared when done pulses.
module tb_division;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } exp_t;

   logic clock;
   logic reset;
   int   total;
   int   bad;
   exp_t sb[$];

   logic [W-1:0] last_q;
   logic [W-1:0] last_r;

   division_if #(.WIDTH(W)) bus ();

   division #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at a negedge; drives start across exactly one rising edge.
   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      if (bv == {W{1'b0}}) begin
         e.q = {W{1'b1}};
         e.r = av;
      end else begin
         e.q = av / bv;
         e.r = av % bv;
      end
      e.dbz = (bv == {W{1'b0}});
      sb.push_back(e);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
   endtask

   // Waits for done (bounded), checks holds during RUN, latency and the result.
   // inject_at > 0 pulses a second start with 9/3 at that cycle.
   task automatic await_result(input int inject_at);
      int   cycles;
      exp_t e;
      cycles = 0;
      do begin
         @(posedge clock);
         cycles++;
         @(negedge clock);
         if (inject_at > 0 && cycles == inject_at) begin
            bus.start = 1'b1;
            bus.a     = 32'd9;
            bus.b     = 32'd3;
         end else if (inject_at > 0 && cycles == inject_at + 1) begin
            bus.start = 1'b0;
         end
         if (bus.done !== 1'b1) begin
            check("busy_run", {63'd0, bus.busy}, 64'd1);
            check("hold_q", {32'd0, bus.q}, {32'd0, last_q});
            check("hold_r", {32'd0, bus.r}, {32'd0, last_r});
         end
      end while (bus.done !== 1'b1 && cycles < 100);
      check("latency", 64'(cycles), 64'(W));
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("q", {32'd0, bus.q}, {32'd0, e.q});
         check("r", {32'd0, bus.r}, {32'd0, e.r});
         check("busy_done", {63'd0, bus.busy}, 64'd0);
`ifdef DIVISION_DBZ_FLAG_EN
         check("dbz", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
`endif
         last_q = e.q;
         last_r = e.r;
      end else begin
         check("sb_empty", 64'd1, 64'd0);
      end
   endtask

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int inject_at);
      launch(av, bv);
      await_result(inject_at);
      @(negedge clock);
      check("done_pulse", {63'd0, bus.done}, 64'd0);
      check("busy_idle", {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      last_q    = {W{1'b0}};
      last_r    = {W{1'b0}};
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.a     = {W{1'b0}};
      bus.b     = {W{1'b0}};
      repeat (3) @(negedge clock);
      check("rst_q", {32'd0, bus.q}, 64'd0);
      check("rst_r", {32'd0, bus.r}, 64'd0);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      reset = 1'b0;
      @(negedge clock);

      run_op(32'd5, 32'd9, 0);
      run_op(32'd100, 32'd7, 0);
      run_op(32'hFFFF_FFFF, 32'd1, 0);
      run_op(32'd1234, 32'd0, 0);
      run_op(32'd10, 32'd3, 0);

      // Second start while busy must be ignored.
      run_op(32'd100, 32'd7, 10);
      repeat (5) @(negedge clock);
      check("ignored_busy", {63'd0, bus.busy}, 64'd0);
      check("ignored_q", {32'd0, bus.q}, 64'd14);

      // Asynchronous reset mid-operation.
      launch(32'd1000, 32'd10);
      repeat (15) @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("arst_q", {32'd0, bus.q}, 64'd0);
      check("arst_r", {32'd0, bus.r}, 64'd0);
      check("arst_busy", {63'd0, bus.busy}, 64'd0);
      check("arst_done", {63'd0, bus.done}, 64'd0);
      sb.delete();
      last_q = {W{1'b0}};
      last_r = {W{1'b0}};
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_op(32'd1000, 32'd10, 0);

      // Back-to-back: next start raised in the done cycle.
      launch(32'd50, 32'd5);
      await_result(0);
      launch(32'd49, 32'd5);
      await_result(0);
      @(negedge clock);
      check("b2b_done", {63'd0, bus.done}, 64'd0);

      for (int i = 0; i < 4; i++) begin
         run_op(W'($urandom), W'($urandom_range(1, 5000)), 0);
      end
      run_op(32'd3, 32'hFFFF_FFFF, 0);
      run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
